// File: rtl/fpu_ctrl_pkg.sv
// Shared types for the FPU issue/stall sequencer: state encoding, FPU op codes
// and the per-op fixed latency lookup.
package fpu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } fpu_state_e;

    localparam logic [1:0] OP_FADD = 2'b00;
    localparam logic [1:0] OP_FSUB = 2'b01;
    localparam logic [1:0] OP_FMUL = 2'b10;
    localparam logic [1:0] OP_FDIV = 2'b11;

    localparam int CNT_W = 4;

    function automatic logic [CNT_W-1:0] op_latency(input logic [1:0] op,
                                                    input int lat_add,
                                                    input int lat_mul,
                                                    input int lat_div);
        logic [CNT_W-1:0] lat;
        case (op)
            OP_FMUL: lat = lat_mul[CNT_W-1:0];
            OP_FDIV: lat = lat_div[CNT_W-1:0];
            default: lat = lat_add[CNT_W-1:0];
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/fpu_lat_counter.sv
// Loadable 4-bit down-counter timing a fixed-latency FPU operation; at_one
// flags the last execute cycle. Decrement saturates at zero so it never wraps.
module fpu_lat_counter
    import fpu_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             at_one
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_one = (count_q == CNT_W'(1));

endmodule

// File: rtl/fpu_seq_ctrl.sv
// Multi-cycle FPU issue/stall sequencer: holds decode while the FPU runs, then
// performs a one-cycle register-file write. Macro FPU_EXT_DONE_EN switches the
// execute exit from fixed per-op latency to the FPU's fpuDone strobe.
module fpu_seq_ctrl
    import fpu_ctrl_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int LAT_ADD = 2,
    parameter int LAT_MUL = 3,
    parameter int LAT_DIV = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instrValid,
    input  logic              ALUorFPU,
    input  logic [1:0]        FPUOp,
    input  logic [2:0]        destReg,
    input  logic [DATA_W-1:0] fpuResult,
    input  logic              fpuDone,
    output logic              fpuStart,
    output logic [1:0]        fpuOpOut,
    output logic              stall,
    output logic              busy,
    output logic              fpuWrEn,
    output logic [2:0]        fpuWrAddr,
    output logic [DATA_W-1:0] fpuWrData
);

    fpu_state_e        state_q, state_d;
    logic              start_q;
    logic [1:0]        op_q;
    logic [2:0]        addr_q;
    logic [DATA_W-1:0] data_q;

    logic issue;
    logic issue_now;
    logic exec_done;
    logic capture;

    assign issue     = instrValid & ALUorFPU;
    assign issue_now = (state_q == IDLE) && issue;

`ifdef FPU_EXT_DONE_EN
    localparam int unused_lat = LAT_ADD + LAT_MUL + LAT_DIV;

    assign exec_done = fpuDone;
`else
    logic unused_done;
    logic at_one;

    assign unused_done = fpuDone;

    fpu_lat_counter u_lat_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (issue_now),
        .load_val_i (op_latency(FPUOp, LAT_ADD, LAT_MUL, LAT_DIV)),
        .dec_i      (state_q == EXEC),
        .at_one     (at_one)
    );

    assign exec_done = at_one;
`endif

    assign capture = (state_q == EXEC) && exec_done;

    // WB ignores issue: the retiring instruction is still on the decode outputs.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d = EXEC;
                    stall   = 1'b1;
                end
            end
            EXEC: begin
                stall = 1'b1;
                if (exec_done) begin
                    state_d = WB;
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            op_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            start_q <= issue_now;
            if (issue_now) begin
                op_q   <= FPUOp;
                addr_q <= destReg;
            end
            if (capture) begin
                data_q <= fpuResult;
            end
        end
    end

    assign fpuStart  = start_q;
    assign fpuOpOut  = op_q;
    assign busy      = (state_q != IDLE);
    assign fpuWrEn   = (state_q == WB);
    assign fpuWrAddr = addr_q;
    assign fpuWrData = data_q;

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// Self-checking bench for fpu_seq_ctrl: directed scenarios plus random traffic
// compared against a cycle-offset reference model (honours FPU_EXT_DONE_EN).
module tb_fpu_seq_ctrl;

    localparam int DW = 16;
    localparam int LA = 2;
    localparam int LM = 3;
    localparam int LD = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          instrValid;
    logic          ALUorFPU;
    logic [1:0]    FPUOp;
    logic [2:0]    destReg;
    logic [DW-1:0] fpuResult;
    logic          fpuDone;
    logic          fpuStart;
    logic [1:0]    fpuOpOut;
    logic          stall;
    logic          busy;
    logic          fpuWrEn;
    logic [2:0]    fpuWrAddr;
    logic [DW-1:0] fpuWrData;

    always #5 clk = ~clk;

    fpu_seq_ctrl #(
        .DATA_W  (DW),
        .LAT_ADD (LA),
        .LAT_MUL (LM),
        .LAT_DIV (LD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .instrValid (instrValid),
        .ALUorFPU   (ALUorFPU),
        .FPUOp      (FPUOp),
        .destReg    (destReg),
        .fpuResult  (fpuResult),
        .fpuDone    (fpuDone),
        .fpuStart   (fpuStart),
        .fpuOpOut   (fpuOpOut),
        .stall      (stall),
        .busy       (busy),
        .fpuWrEn    (fpuWrEn),
        .fpuWrAddr  (fpuWrAddr),
        .fpuWrData  (fpuWrData)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: an instruction issued at cycle t0 is described purely by
    // its offset k = cyc - t0; execute ends at offset k_end, the write follows.
    bit            m_active = 1'b0;
    int            m_t0     = 0;
    int            m_lat    = 0;
    int            m_k_end  = -1;
    int            cyc      = 0;
    logic [1:0]    m_op     = '0;
    logic [2:0]    m_addr   = '0;
    logic [DW-1:0] m_data   = '0;
    int            stall_seen = 0;
    int            wr_seen    = 0;
    int            start_seen = 0;

    function automatic int lat_for(input logic [1:0] op);
        if (op == 2'b11) return LD;
        if (op == 2'b10) return LM;
        return LA;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic step(input logic iv, input logic af, input logic [1:0] op,
                        input logic [2:0] dr, input logic [DW-1:0] res, input logic dn);
        logic e_stall, e_start, e_wr, e_busy, cap;
        int   k;
        @(negedge clk);
        instrValid = iv;
        ALUorFPU   = af;
        FPUOp      = op;
        destReg    = dr;
        fpuResult  = res;
        fpuDone    = dn;
        #1;
        e_stall = 1'b0;
        e_start = 1'b0;
        e_wr    = 1'b0;
        e_busy  = 1'b0;
        cap     = 1'b0;
        if (!m_active) begin
            e_stall = iv & af;
        end else begin
            k      = cyc - m_t0;
            e_busy = 1'b1;
            if (m_k_end < 0) begin
                e_stall = 1'b1;
                e_start = (k == 1);
`ifdef FPU_EXT_DONE_EN
                cap = dn;
`else
                cap = (k == m_lat);
`endif
                if (cap) m_k_end = k;
            end else begin
                e_wr = 1'b1;
            end
        end
        chk("stall", 32'(stall), 32'(e_stall));
        chk("fpuStart", 32'(fpuStart), 32'(e_start));
        chk("fpuWrEn", 32'(fpuWrEn), 32'(e_wr));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("fpuOpOut", 32'(fpuOpOut), 32'(m_op));
        chk("fpuWrAddr", 32'(fpuWrAddr), 32'(m_addr));
        chk("fpuWrData", 32'(fpuWrData), 32'(m_data));
        stall_seen += int'(stall);
        wr_seen    += int'(fpuWrEn);
        start_seen += int'(fpuStart);
        if (!m_active && iv && af) begin
            m_active = 1'b1;
            m_t0     = cyc;
            m_lat    = lat_for(op);
            m_k_end  = -1;
            m_op     = op;
            m_addr   = dr;
        end else if (m_active && e_wr) begin
            m_active = 1'b0;
        end
        if (cap) m_data = res;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        instrValid = 1'b0;
        ALUorFPU   = 1'b0;
        fpuDone    = 1'b0;
        #1;
        m_active = 1'b0;
        m_op     = '0;
        m_addr   = '0;
        m_data   = '0;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wren", 32'(fpuWrEn), 32'd0);
        chk("rst_start", 32'(fpuStart), 32'd0);
        chk("rst_op", 32'(fpuOpOut), 32'd0);
        chk("rst_addr", 32'(fpuWrAddr), 32'd0);
        chk("rst_data", 32'(fpuWrData), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    // Holds one FPU instruction on the decode outputs for n steps, raising
    // fpuDone at step done_at (matches the fixed latency in the default build).
    task automatic run_op(input logic [1:0] op, input logic [2:0] dr, input int n,
                          input int done_at, input logic [DW-1:0] cap_val);
        for (int j = 0; j < n; j++) begin
            step(1'b1, 1'b1, op, dr,
                 (j == done_at) ? cap_val : DW'($urandom), (j == done_at));
        end
    endtask

    initial begin
        reset      = 1'b1;
        instrValid = 1'b0;
        ALUorFPU   = 1'b0;
        FPUOp      = '0;
        destReg    = '0;
        fpuResult  = '0;
        fpuDone    = 1'b0;
        do_reset();

        // Non-FPU traffic only.
        wr_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 2'($urandom), 3'($urandom), DW'($urandom), 1'b0);
        end
        chk("idle_no_write", 32'(wr_seen), 32'd0);

        // FADD r3: stall 0..2, write in cycle 3 with 16'h3C00.
        stall_seen = 0; wr_seen = 0;
        run_op(2'b00, 3'd3, 1 + LA + 1, LA, 16'h3C00);
        step(1'b0, 1'b0, 2'b00, 3'd0, 16'h0, 1'b0);
        chk("fadd_stall_cycles", 32'(stall_seen), 32'(1 + LA));
        chk("fadd_writes", 32'(wr_seen), 32'd1);
        chk("fadd_data", 32'(fpuWrData), 32'h3C00);

        // FDIV r5: nine stall cycles, single write.
        stall_seen = 0; wr_seen = 0;
        run_op(2'b11, 3'd5, 1 + LD + 1, LD, 16'hBEEF);
        step(1'b0, 1'b0, 2'b00, 3'd0, 16'h0, 1'b0);
        chk("fdiv_stall_cycles", 32'(stall_seen), 32'd9);
        chk("fdiv_writes", 32'(wr_seen), 32'd1);

        // FMUL r1 immediately followed by FSUB r6.
        wr_seen = 0; start_seen = 0;
        run_op(2'b10, 3'd1, 1 + LM + 1, LM, 16'h1234);
        run_op(2'b01, 3'd6, 1 + LA + 1, LA, 16'h5678);
        step(1'b0, 1'b0, 2'b00, 3'd0, 16'h0, 1'b0);
        chk("b2b_writes", 32'(wr_seen), 32'd2);
        chk("b2b_starts", 32'(start_seen), 32'd2);
        chk("b2b_last_addr", 32'(fpuWrAddr), 32'd6);

        // Reset in the second EXEC cycle of FDIV.
        wr_seen = 0;
        run_op(2'b11, 3'd2, 2, LD, 16'h0);
        do_reset();
        step(1'b0, 1'b0, 2'b00, 3'd0, 16'h0, 1'b0);
        step(1'b0, 1'b0, 2'b00, 3'd0, 16'h0, 1'b0);
        chk("rst_mid_no_write", 32'(wr_seen), 32'd0);

`ifdef FPU_EXT_DONE_EN
        // fpuDone 5 cycles after fpuStart; FADD's fixed latency must not matter.
        stall_seen = 0; wr_seen = 0;
        run_op(2'b00, 3'd4, 8, 6, 16'hA5A5);
        step(1'b0, 1'b0, 2'b00, 3'd0, 16'h0, 1'b0);
        chk("ext_stall_cycles", 32'(stall_seen), 32'd7);
        chk("ext_writes", 32'(wr_seen), 32'd1);
        chk("ext_data", 32'(fpuWrData), 32'hA5A5);
        // One-cycle FPU: done in the start cycle.
        run_op(2'b11, 3'd7, 3, 1, 16'h0F0F);
        step(1'b0, 1'b0, 2'b00, 3'd0, 16'h0, 1'b0);
        chk("ext_fast_data", 32'(fpuWrData), 32'h0F0F);
`endif

        // Random decode traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom), ($urandom_range(0, 2) != 0), 2'($urandom), 3'($urandom),
                 DW'($urandom), ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpu_seq_ctrl.md
# fpu_seq_ctrl

Multi-cycle issue/stall sequencer for the FPU datapath in the 16-bit core. Decoded FPU instructions (FADD/FSUB/FMUL/FDIV) are held at decode while the FPU computes. The block pulses the FPU start, counts the per-op latency, captures the result, and drives a one-cycle register-file write. It freezes PC/fetch/decode via `stall` for the duration and sits between the decoder outputs (`ALUorFPU`, `FPUOp`, `RegWrite`) and the FPU/register-file write port.

## Interface
Parameters:
- `DATA_W`, 16, FPU operand/result width
- `LAT_ADD`, 2, execute cycles for FADD/FSUB (legal 1..15)
- `LAT_MUL`, 3, execute cycles for FMUL (legal 1..15)
- `LAT_DIV`, 8, execute cycles for FDIV (legal 1..15)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `instrValid`  in  1  decode stage holds a valid instruction
- `ALUorFPU`  in  1  decoded: 1 = FPU instruction
- `FPUOp`  in  2  decoded op: 00 FADD, 01 FSUB, 10 FMUL, 11 FDIV
- `destReg`  in  3  destination register index
- `fpuResult`  in  DATA_W  FPU result bus
- `fpuDone`  in  1  FPU completion strobe (used only with macro)
- `fpuStart`  out  1  one-cycle start pulse to FPU
- `fpuOpOut`  out  2  latched op, stable for whole operation
- `stall`  out  1  freeze PC, fetch and decode
- `busy`  out  1  state != IDLE
- `fpuWrEn`  out  1  register-file write enable
- `fpuWrAddr`  out  3  latched destReg
- `fpuWrData`  out  DATA_W  captured result

## Operation
- States: IDLE, EXEC, WB.
- IDLE:
  - `issue = instrValid & ALUorFPU`.
  - On issue: latch `FPUOp` and `destReg`, load counter with LAT for that op, go to EXEC.
  - `stall` is combinationally high in the issue cycle.
- EXEC:
  - `fpuStart` = 1 in the first EXEC cycle only.
  - Counter decrements each cycle.
  - When counter == 1: capture `fpuResult` into the result register at that edge and go to WB.
  - `stall` = 1 throughout.
- WB:
  - `fpuWrEn` = 1, `stall` = 0; the FPU instruction retires.
  - Next state is always IDLE.
  - `issue` is ignored in WB, because the retiring instruction is still presented and must not re-issue.
- `fpuOpOut`, `fpuWrAddr` and `fpuWrData` hold their latched values until the next issue/capture.
- Non-FPU instructions in IDLE: no effect, `stall` = 0.
- Flags are never touched (FPU ops keep flags).

## Timing
- Reset values (all asynchronous):
  - state = IDLE, counter = 0.
  - `fpuStart`, `stall`, `busy`, `fpuWrEn` = 0.
  - `fpuOpOut` = 0, `fpuWrAddr` = 0, `fpuWrData` = 0.
- Stall cycles per op = 1 + LAT; the write occurs in cycle 1 + LAT relative to the issue cycle 0.
  - FADD: stall cycles 0–2, write cycle 3.
  - FDIV: stall cycles 0–8, write cycle 9.
- LAT = 1: a single EXEC cycle that carries both `fpuStart` and the capture.
- Back-to-back FPU instructions: the second is seen in the cycle after WB, so there is no overlap and the minimum spacing is 2 + LAT.
- Reset mid-EXEC or mid-WB: return to IDLE immediately, with no write and no start pulse.
- Counter is 4 bits and never wraps: it is loaded only in IDLE and leaves EXEC at 1.

## Configuration
- Macro `FPU_EXT_DONE_EN`.
- Defined:
  - EXEC exits on `fpuDone` = 1 instead of counter == 1, and `fpuResult` is captured on that edge.
  - The counter is removed and the LAT parameters are unused.
  - `fpuDone` in the `fpuStart` cycle is legal (one-cycle FPU).
- Undefined:
  - Fixed per-op latencies apply and `fpuDone` is ignored.

## Structure
- Shared package `fpu_ctrl_pkg`:
  - state enum (IDLE/EXEC/WB);
  - FPUOp encodings (FADD/FSUB/FMUL/FDIV);
  - a function mapping op to latency.
- One sub-module `fpu_lat_counter`: a loadable 4-bit down-counter with an `at_one` output. It is instantiated only when `FPU_EXT_DONE_EN` is undefined.

## Test plan
- Reset, then idle with `ALUorFPU` = 0 → `stall` = 0, `fpuWrEn` never asserts, all outputs 0.
- FADD to r3 with `fpuResult` = 16'h3C00 present at the capture edge:
  - `fpuStart` in cycle 1;
  - `stall` in cycles 0–2;
  - cycle 3: `fpuWrEn` = 1, `fpuWrAddr` = 3, `fpuWrData` = 16'h3C00.
- FDIV to r5 → `stall` for exactly 9 cycles, a single write in cycle 9, and `fpuOpOut` = 11 throughout.
- FMUL immediately followed by FSUB → two writes with correct addresses, no re-issue during WB, and the second `fpuStart` exactly 2 cycles after the first write.
- Reset asserted in the 2nd EXEC cycle of FDIV → next cycle IDLE, no `fpuWrEn`, `stall` = 0.
- With `FPU_EXT_DONE_EN`, `fpuDone` asserted 5 cycles after `fpuStart` → write in the following cycle with the captured data, and the LAT values have no effect.
